// File: rtl/fir_output_stage.sv
// FIR output stage: rounds and saturates full-width MAC results to OUT_W bits,
// tags each with a 6-bit in-frame sample index and buffers them in a small FIFO
// for a valid/ready consumer. Admission is credit-based, so the FIFO never overflows.
// Optional build macro SAT_COUNT_EN adds a 16-bit saturating counter of saturation
// events on sat_count. Without it, sat_count is tied to 0.
module fir_output_stage #(
    parameter int unsigned ACC_W      = 40,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned FRAC_SHIFT = 15,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                     clk_10kHz,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     acc_valid,
    input  logic signed [ACC_W-1:0]  acc_data,
    output logic                     acc_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [5:0]               out_idx,
    output logic                     frame_done,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     sat_flag,
    output logic                     drop_err,
    output logic [15:0]              sat_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    // Half an output LSB, added before the shift so rounding is half-up.
    localparam logic signed [ACC_W:0] RoundConst = {{ACC_W{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_W:0] SatMax =
        {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SatMin =
        {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic                    accept;
    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   round_sum;
    logic signed [ACC_W:0]   s1_r_d;
    logic [LvlW:0]           credit_used;

    logic                    s1_v_q;
    logic signed [ACC_W:0]   s1_r_q;
    logic [5:0]              s1_idx_q;
    logic [OUT_W-1:0]        s2_data_d;
    logic                    s2_sat_d;
    logic                    s2_v_q;
    logic [OUT_W-1:0]        s2_data_q;
    logic [5:0]              s2_idx_q;

    logic [5:0]              in_idx_q;
    logic                    sat_flag_q;
    logic                    drop_err_q;
    logic                    frame_done_q;

    logic [OUT_W-1:0]        mem_data [DEPTH];
    logic [5:0]              mem_idx  [DEPTH];
    logic [PtrW-1:0]         wr_ptr_q;
    logic [PtrW-1:0]         rd_ptr_q;
    logic [LvlW-1:0]         level_q;
    logic                    fifo_wr;
    logic                    fifo_pop;

    // Words already in S1/S2 hold a FIFO slot, so they count against the credit.
    assign credit_used = {1'b0, level_q} + {{LvlW{1'b0}}, s1_v_q} + {{LvlW{1'b0}}, s2_v_q};
    assign acc_ready   = credit_used < (LvlW + 1)'(DEPTH);
    assign accept      = acc_valid && acc_ready;

    // One extra bit of headroom so the rounding add cannot wrap.
    assign acc_ext   = {acc_data[ACC_W-1], acc_data};
    assign round_sum = acc_ext + RoundConst;
    assign s1_r_d    = round_sum >>> FRAC_SHIFT;

    // S2 combinational clamp of the rounded value into the output range.
    always_comb begin
        s2_sat_d  = 1'b0;
        s2_data_d = s1_r_q[OUT_W-1:0];
        if (s1_r_q > SatMax) begin
            s2_data_d = {1'b0, {(OUT_W - 1){1'b1}}};
            s2_sat_d  = 1'b1;
        end else if (s1_r_q < SatMin) begin
            s2_data_d = {1'b1, {(OUT_W - 1){1'b0}}};
            s2_sat_d  = 1'b1;
        end
    end

    // Two-stage round/saturate pipeline carrying the sample index alongside.
    always_ff @(posedge clk_10kHz or posedge reset) begin
        if (reset) begin
            s1_v_q    <= 1'b0;
            s1_r_q    <= '0;
            s1_idx_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_idx_q  <= '0;
        end else if (clear) begin
            s1_v_q    <= 1'b0;
            s1_r_q    <= '0;
            s1_idx_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_idx_q  <= '0;
        end else begin
            s1_v_q    <= accept;
            s1_r_q    <= s1_r_d;
            s1_idx_q  <= in_idx_q;
            s2_v_q    <= s1_v_q;
            s2_data_q <= s2_data_d;
            s2_idx_q  <= s1_idx_q;
        end
    end

    // Input index advances only on accepted words; sticky status flags.
    always_ff @(posedge clk_10kHz or posedge reset) begin
        if (reset) begin
            in_idx_q   <= '0;
            sat_flag_q <= 1'b0;
            drop_err_q <= 1'b0;
        end else if (clear) begin
            in_idx_q   <= '0;
            sat_flag_q <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            if (accept) begin
                in_idx_q <= in_idx_q + 6'd1;
            end
            if (s1_v_q && s2_sat_d) begin
                sat_flag_q <= 1'b1;
            end
            if (acc_valid && !acc_ready) begin
                drop_err_q <= 1'b1;
            end
        end
    end

    assign fifo_wr   = s2_v_q && !clear;
    assign out_valid = level_q != '0;
    assign fifo_pop  = out_valid && out_ready && !clear;

    // FIFO storage; contents are don't-care when empty because outputs are gated.
    always_ff @(posedge clk_10kHz) begin
        if (fifo_wr) begin
            mem_data[wr_ptr_q] <= s2_data_q;
            mem_idx[wr_ptr_q]  <= s2_idx_q;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk_10kHz or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({fifo_wr, fifo_pop})
                2'b10:   level_q <= level_q + LvlW'(1);
                2'b01:   level_q <= level_q - LvlW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Frame end pulse, one cycle after the last sample of a frame leaves.
    always_ff @(posedge clk_10kHz or posedge reset) begin
        if (reset) begin
            frame_done_q <= 1'b0;
        end else if (clear) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= fifo_pop && (mem_idx[rd_ptr_q] == 6'd63);
        end
    end

`ifdef SAT_COUNT_EN
    logic [15:0] sat_cnt_q;

    // Saturation event counter, pinned at its maximum.
    always_ff @(posedge clk_10kHz or posedge reset) begin
        if (reset) begin
            sat_cnt_q <= '0;
        end else if (clear) begin
            sat_cnt_q <= '0;
        end else if (s1_v_q && s2_sat_d && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_count = sat_cnt_q;
`else
    assign sat_count = '0;
`endif

    assign out_data   = out_valid ? mem_data[rd_ptr_q] : '0;
    assign out_idx    = out_valid ? mem_idx[rd_ptr_q] : '0;
    assign frame_done = frame_done_q;
    assign fifo_level = level_q;
    assign sat_flag   = sat_flag_q;
    assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_fir_output_stage.sv
// Self-checking bench for fir_output_stage. A queue-based reference model tracks
// every accepted word with the edge it was accepted on; visibility, occupancy,
// credit and flags are derived from that history and compared at each negedge.
module tb_fir_output_stage;

    localparam int DEPTH = 8;

    logic        clk_10kHz = 1'b0;
    logic        reset     = 1'b1;
    logic        clear     = 1'b0;
    logic        acc_valid = 1'b0;
    logic [39:0] acc_data  = '0;
    logic        out_ready = 1'b0;
    logic        acc_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [5:0]  out_idx;
    logic        frame_done;
    logic [3:0]  fifo_level;
    logic        sat_flag;
    logic        drop_err;
    logic [15:0] sat_count;

    fir_output_stage #(
        .ACC_W      (40),
        .OUT_W      (16),
        .FRAC_SHIFT (15),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_10kHz  (clk_10kHz),
        .reset      (reset),
        .clear      (clear),
        .acc_valid  (acc_valid),
        .acc_data   (acc_data),
        .acc_ready  (acc_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .frame_done (frame_done),
        .fifo_level (fifo_level),
        .sat_flag   (sat_flag),
        .drop_err   (drop_err),
        .sat_count  (sat_count)
    );

    always #5 clk_10kHz = ~clk_10kHz;

    typedef struct {
        logic [15:0] data;
        int          idx;
        int          at;
    } ent_t;

    ent_t q[$];      // accepted and not yet popped, oldest first
    int   sat_at[$]; // edges on which saturating words were accepted
    int   cyc;
    int   m_idx;
    bit   m_drop;
    bit   m_fd;
    int   total;
    int   bad;

    function automatic void model_reset();
        q.delete();
        sat_at.delete();
        m_idx  = 0;
        m_drop = 0;
        m_fd   = 0;
    endfunction

    // floor((acc + 2^14) / 2^15) in plain 64-bit arithmetic
    function automatic longint ref_round(input logic [39:0] a);
        longint v;
        v = longint'($signed(a));
        return (v + 64'sd16384) >>> 15;
    endfunction

    function automatic bit ref_sat(input longint r);
        return (r > 32767) || (r < -32768);
    endfunction

    function automatic logic [15:0] ref_out(input longint r);
        longint c;
        c = r;
        if (c > 32767) c = 32767;
        if (c < -32768) c = -32768;
        return c[15:0];
    endfunction

    // Words become visible in the FIFO two edges after the accepting edge.
    function automatic int vis_count();
        int n = 0;
        foreach (q[i]) if (q[i].at + 2 <= cyc) n++;
        return n;
    endfunction

    function automatic int sat_seen();
        int n = 0;
        foreach (sat_at[i]) if (sat_at[i] + 1 <= cyc) n++;
        return n;
    endfunction

    function automatic int exp_sc();
`ifdef SAT_COUNT_EN
        return (sat_seen() > 65535) ? 65535 : sat_seen();
`else
        return 0;
`endif
    endfunction

    function automatic logic [39:0] rnd_acc();
        logic [31:0] r;
        logic [7:0]  h;
        logic [39:0] base;
        r    = $urandom();
        h    = 8'($urandom());
        base = 40'h003FFFC000 - 40'(r[3:0]);
        case ($urandom_range(0, 3))
            0:       return {h, r};
            1:       return {{8{r[31]}}, r};
            2:       return {{25{r[31]}}, r[14:0]};
            default: return r[4] ? base : (40'h0 - base - 40'h4000);
        endcase
    endfunction

    // One clock: drive inputs at negedge, advance model at posedge, return at negedge.
    task automatic tick(input bit v, input logic [39:0] d, input bit r);
        bit     take;
        bit     pop;
        bit     fd;
        longint rr;
        ent_t   e;
        acc_valid = v;
        acc_data  = d;
        out_ready = r;
        take = v && (q.size() < DEPTH);
        pop  = r && (vis_count() > 0);
        @(posedge clk_10kHz);
        cyc++;
        if (clear) begin
            model_reset();
        end else begin
            fd = 0;
            if (pop) begin
                fd = (q[0].idx == 63);
                void'(q.pop_front());
            end
            m_fd = fd;
            if (v && !take) m_drop = 1;
            if (take) begin
                rr     = ref_round(d);
                e.data = ref_out(rr);
                e.idx  = m_idx;
                e.at   = cyc;
                q.push_back(e);
                if (ref_sat(rr)) sat_at.push_back(cyc);
                m_idx = (m_idx + 1) % 64;
            end
        end
        @(negedge clk_10kHz);
        acc_valid = 0;
        out_ready = 0;
        clear     = 0;
    endtask

    task automatic do_clear();
        clear = 1;
        tick(0, '0, 0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_10kHz);
        reset = 0;
        model_reset();
        @(negedge clk_10kHz);
        total++;
        if ({acc_ready, out_valid, frame_done, sat_flag, drop_err} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=10000",
                     {acc_ready, out_valid, frame_done, sat_flag, drop_err});
        end
        total++;
        if ({out_data, out_idx, fifo_level, sat_count} !== 42'd0) begin
            bad++;
            $display("FAIL reset_values data=%h idx=%0d lvl=%0d sc=%0d exp all 0",
                     out_data, out_idx, fifo_level, sat_count);
        end
    endtask

    task automatic test_rounding();
        logic [39:0] va [4];
        logic [15:0] ve [4];
        va = '{40'h0000004000, 40'h0000003FFF, 40'hFFFFFFFFFF, 40'hFFC0000000};
        ve = '{16'h0001, 16'h0000, 16'h0000, 16'h8000};
        do_clear();
        for (int i = 0; i < 4; i++) begin
            tick(1, va[i], 0);
            tick(0, '0, 0);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL round_early_valid[%0d] got=%b exp=0", i, out_valid);
            end
            tick(0, '0, 0);
            total++;
            if (out_valid !== 1'b1 || out_data !== ve[i] || out_idx !== 6'(i)) begin
                bad++;
                $display("FAIL round_out[%0d] got v=%b d=%h i=%0d exp v=1 d=%h i=%0d",
                         i, out_valid, out_data, out_idx, ve[i], i);
            end
            tick(0, '0, 1);
        end
        total++;
        if (sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL round_sat_flag got=%b exp=0", sat_flag);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_cnt;
`ifdef SAT_COUNT_EN
        exp_cnt = 16'd2;
`else
        exp_cnt = 16'd0;
`endif
        do_clear();
        tick(1, 40'h7FFFFFFFFF, 0);
        tick(0, '0, 0);
        total++;
        if (sat_flag !== 1'b1) begin
            bad++;
            $display("FAIL sat_flag_pos got=%b exp=1", sat_flag);
        end
        tick(0, '0, 0);
        total++;
        if (out_data !== 16'h7FFF) begin
            bad++;
            $display("FAIL sat_pos got=%h exp=7fff", out_data);
        end
        tick(1, 40'h8000000000, 1);
        tick(0, '0, 0);
        tick(0, '0, 0);
        total++;
        if (out_data !== 16'h8000 || out_idx !== 6'd1) begin
            bad++;
            $display("FAIL sat_neg got=%h/%0d exp=8000/1", out_data, out_idx);
        end
        total++;
        if (sat_count !== exp_cnt) begin
            bad++;
            $display("FAIL sat_count got=%0d exp=%0d", sat_count, exp_cnt);
        end
        tick(0, '0, 1);
    endtask

    task automatic test_backpressure();
        do_clear();
        for (int i = 0; i < 12; i++) begin
            total++;
            if (acc_ready !== (i < 8)) begin
                bad++;
                $display("FAIL bp_ready[%0d] got=%b exp=%b", i, acc_ready, i < 8);
            end
            tick(1, rnd_acc(), 0);
        end
        tick(0, '0, 0);
        tick(0, '0, 0);
        total++;
        if (fifo_level !== 4'd8 || drop_err !== 1'b1 || acc_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_full got lvl=%0d drop=%b rdy=%b exp 8/1/0",
                     fifo_level, drop_err, acc_ready);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (out_idx !== 6'(i) || out_data !== q[0].data) begin
                bad++;
                $display("FAIL bp_drain[%0d] got=%0d/%h exp=%0d/%h",
                         i, out_idx, out_data, i, q[0].data);
            end
            tick(0, '0, 1);
        end
        total++;
        if (out_valid !== 1'b0 || acc_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_empty got v=%b rdy=%b exp 0/1", out_valid, acc_ready);
        end
    endtask

    task automatic test_frame();
        int pops = 0;
        int fds  = 0;
        do_clear();
        for (int n = 0; n < 80; n++) begin
            if (out_valid === 1'b1) begin
                total++;
                if (out_idx !== 6'(pops % 64)) begin
                    bad++;
                    $display("FAIL frame_idx[%0d] got=%0d exp=%0d", pops, out_idx, pops % 64);
                end
                pops++;
            end
            total++;
            if (frame_done !== m_fd) begin
                bad++;
                $display("FAIL frame_done[%0d] got=%b exp=%b", n, frame_done, m_fd);
            end
            if (frame_done === 1'b1) fds++;
            tick(n < 66, rnd_acc(), 1);
        end
        total++;
        if (pops != 66 || fds != 1) begin
            bad++;
            $display("FAIL frame_count got pops=%0d fds=%0d exp 66/1", pops, fds);
        end
    endtask

    task automatic test_clear();
        do_clear();
        for (int i = 0; i < 5; i++) tick(1, rnd_acc(), 0);
        clear = 1;
        tick(1, rnd_acc(), 1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b0 || fifo_level !== 4'd0 || acc_ready !== 1'b1) begin
                bad++;
                $display("FAIL clear_flush[%0d] got v=%b lvl=%0d rdy=%b exp 0/0/1",
                         i, out_valid, fifo_level, acc_ready);
            end
            tick(0, '0, 0);
        end
        tick(1, 40'h0000008000, 0);
        tick(0, '0, 0);
        tick(0, '0, 0);
        total++;
        if (out_valid !== 1'b1 || out_idx !== 6'd0 || out_data !== 16'h0001) begin
            bad++;
            $display("FAIL clear_restart got v=%b i=%0d d=%h exp 1/0/0001",
                     out_valid, out_idx, out_data);
        end
        tick(0, '0, 1);
    endtask

    task automatic test_reset_midframe();
        do_clear();
        for (int i = 0; i < 5; i++) tick(1, rnd_acc(), 0);
        repeat (3) tick(0, '0, 0);
        total++;
        if (fifo_level !== 4'd5) begin
            bad++;
            $display("FAIL mid_level got=%0d exp=5", fifo_level);
        end
        reset = 1;
        #1;
        model_reset();
        total++;
        if (fifo_level !== 4'd0 || out_valid !== 1'b0 || acc_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset got lvl=%0d v=%b rdy=%b exp 0/0/1",
                     fifo_level, out_valid, acc_ready);
        end
        @(negedge clk_10kHz);
        reset = 0;
        tick(1, rnd_acc(), 0);
        tick(0, '0, 0);
        tick(0, '0, 0);
        total++;
        if (out_valid !== 1'b1 || out_idx !== 6'd0 || out_data !== q[0].data) begin
            bad++;
            $display("FAIL mid_restart got v=%b i=%0d d=%h exp 1/0/%h",
                     out_valid, out_idx, out_data, q[0].data);
        end
        tick(0, '0, 1);
    endtask

    task automatic test_random();
        int  vis;
        bit  rdy_phase = 1;
        do_clear();
        for (int n = 0; n < 1500; n++) begin
            vis = vis_count();
            total++;
            if (acc_ready !== (q.size() < DEPTH) || out_valid !== (vis > 0) ||
                fifo_level !== 4'(vis)) begin
                bad++;
                $display("FAIL rnd_ctrl[%0d] got rdy=%b v=%b lvl=%0d exp %b/%b/%0d",
                         n, acc_ready, out_valid, fifo_level, q.size() < DEPTH, vis > 0, vis);
            end
            if (vis > 0) begin
                total++;
                if (out_data !== q[0].data || out_idx !== 6'(q[0].idx)) begin
                    bad++;
                    $display("FAIL rnd_head[%0d] got=%h/%0d exp=%h/%0d",
                             n, out_data, out_idx, q[0].data, q[0].idx);
                end
            end
            total++;
            if (frame_done !== m_fd || sat_flag !== (sat_seen() > 0) || drop_err !== m_drop ||
                sat_count !== 16'(exp_sc())) begin
                bad++;
                $display("FAIL rnd_flags[%0d] got fd=%b sf=%b de=%b sc=%0d exp %b/%b/%b/%0d",
                         n, frame_done, sat_flag, drop_err, sat_count,
                         m_fd, sat_seen() > 0, m_drop, exp_sc());
            end
            if ($urandom_range(0, 19) == 0) rdy_phase = !rdy_phase;
            if ($urandom_range(0, 399) == 0) clear = 1;
            tick($urandom_range(0, 9) < 7, rnd_acc(),
                 rdy_phase && ($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        model_reset();
        test_reset();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_frame();
        test_clear();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
